// File: rtl/fft_pkg.sv
// Shared types and elaboration-time helpers for the iterative FFT core.
// Contents: FSM state enum, bit-reversal helper, twiddle quantiser.
// The complex sample struct is declared in fft_iter, because its width
// follows that module's DATA_W parameter.
package fft_pkg;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        UNLOAD  = 2'd2
    } state_t;

    localparam real PI = 3.14159265358979323846;

    // Reverse the low 'bits' bits of x.
    function automatic int unsigned bitrev(input int unsigned x, input int unsigned bits);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < bits; i++) begin
            r = (r << 1) | ((x >> i) & 32'd1);
        end
        return r;
    endfunction

    // One twiddle component of W^k = cos(2pi k/n) - j sin(2pi k/n).
    // The result is rounded to nearest and saturated to Q1.(tw_w-1).
    function automatic int tw_quant(input int k, input int n, input int tw_w, input bit imag);
        real ang;
        real v;
        int  q;
        int  lim;
        ang = 2.0 * PI * $itor(k) / $itor(n);
        v   = imag ? -$sin(ang) : $cos(ang);
        q   = $rtoi($floor(v * $itor(1 << (tw_w - 1)) + 0.5));
        lim = (1 << (tw_w - 1)) - 1;
        if (q > lim)
            q = lim;
        if (q < -lim - 1)
            q = -lim - 1;
        return q;
    endfunction

endpackage

// File: rtl/fft_bfly.sv
// Radix-2 DIT butterfly: t = B*W (or t = B when bypass), top = (A+t)/2,
// bot = (A-t)/2. This block is purely combinational.
// Ports: a_*/b_* are the complex inputs, w_* is the twiddle in Q1.(TW_W-1),
//        bypass selects W = +1, and top_*_c/bot_*_c are the results.
module fft_bfly #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned TW_W   = 8
) (
    input  logic signed [DATA_W-1:0] a_re,
    input  logic signed [DATA_W-1:0] a_im,
    input  logic signed [DATA_W-1:0] b_re,
    input  logic signed [DATA_W-1:0] b_im,
    input  logic signed [TW_W-1:0]   w_re,
    input  logic signed [TW_W-1:0]   w_im,
    input  logic                     bypass,
    output logic signed [DATA_W-1:0] top_re_c,
    output logic signed [DATA_W-1:0] top_im_c,
    output logic signed [DATA_W-1:0] bot_re_c,
    output logic signed [DATA_W-1:0] bot_im_c
);

    localparam int unsigned PW = DATA_W + TW_W + 1;
    localparam int unsigned SW = DATA_W + 2;

    logic signed [PW-1:0] p_re, p_im;
    logic signed [SW-1:0] t_re, t_im;
    logic signed [SW-1:0] s_re, s_im, d_re, d_im;

    // Full-width complex product, floor-scaled back to data range, then add/sub and halve.
    always_comb begin
        p_re = PW'(b_re) * PW'(w_re) - PW'(b_im) * PW'(w_im);
        p_im = PW'(b_re) * PW'(w_im) + PW'(b_im) * PW'(w_re);
        if (bypass) begin
            t_re = SW'(b_re);
            t_im = SW'(b_im);
        end else begin
            t_re = SW'(p_re >>> (TW_W - 1));
            t_im = SW'(p_im >>> (TW_W - 1));
        end
        s_re = SW'(a_re) + t_re;
        s_im = SW'(a_im) + t_im;
        d_re = SW'(a_re) - t_re;
        d_im = SW'(a_im) - t_im;
        top_re_c = DATA_W'(s_re >>> 1);
        top_im_c = DATA_W'(s_im >>> 1);
        bot_re_c = DATA_W'(d_re >>> 1);
        bot_im_c = DATA_W'(d_im >>> 1);
    end

endmodule

// File: rtl/fft_iter.sv
// Iterative in-place radix-2 DIT FFT/IFFT. It runs one butterfly per cycle
// and scales every stage by 1/2.
// Ports: clk/rst (synchronous, active high); in_valid/in_ready/in_real/in_imag/inv
//        form the input stream (inv is sampled on the first beat);
//        out_valid/out_ready/out_real/out_imag/out_index/out_last form the
//        natural-order bin stream; busy is high during COMPUTE and UNLOAD.
module fft_iter
    import fft_pkg::*;
#(
    parameter int unsigned N      = 8,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned TW_W   = 8,
    parameter int unsigned LOG2N  = $clog2(N)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_real,
    input  logic signed [DATA_W-1:0] in_imag,
    input  logic                     inv,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_real,
    output logic signed [DATA_W-1:0] out_imag,
    output logic [LOG2N-1:0]         out_index,
    output logic                     out_last,
    output logic                     busy
);

    localparam int unsigned HALF = N / 2;
    localparam int unsigned BW   = LOG2N - 1;

    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
    } cplx_t;

    cplx_t mem [N];

    state_t             state_q, state_d;
    logic [LOG2N-1:0]   cnt_q, cnt_d;
    logic [LOG2N-1:0]   stage_q, stage_d;
    logic [BW-1:0]      bfly_q, bfly_d;
    logic               inv_q, inv_d;
    logic               in_ready_d, out_valid_d, out_last_d, busy_d;
    logic signed [DATA_W-1:0] out_real_d, out_imag_d;
    logic [LOG2N-1:0]   out_index_d;
    logic               wr_ld, wr_bf;

    logic [LOG2N-1:0]   ld_addr, b_ext, span, mask, top_addr, bot_addr;
    logic [BW-1:0]      tw_k;
    logic signed [TW_W-1:0] w_re, w_im;
    logic               bypass;
    cplx_t              top_res, bot_res;

    // Twiddle ROM for k = 0..N/2-1, forward direction.
    logic signed [TW_W-1:0] tw_re_rom [HALF];
    logic signed [TW_W-1:0] tw_im_rom [HALF];

    for (genvar g = 0; g < HALF; g++) begin : g_tw
        localparam int CR = tw_quant(int'(g), int'(N), int'(TW_W), 1'b0);
        localparam int CI = tw_quant(int'(g), int'(N), int'(TW_W), 1'b1);
        assign tw_re_rom[g] = TW_W'(CR);
        assign tw_im_rom[g] = TW_W'(CI);
    end

    // Address generation for the current butterfly. The inverse transform uses
    // the conjugate twiddle; when negating it, -1.0 saturates to the largest
    // positive value.
    always_comb begin
        ld_addr  = LOG2N'(bitrev(32'(cnt_q), LOG2N));
        b_ext    = LOG2N'(bfly_q);
        span     = LOG2N'(1) << stage_q;
        mask     = span - LOG2N'(1);
        top_addr = ((b_ext >> stage_q) << (stage_q + LOG2N'(1))) | (b_ext & mask);
        bot_addr = top_addr | span;
        tw_k     = BW'((b_ext & mask) << (LOG2N'(LOG2N - 1) - stage_q));
        bypass   = (tw_k == '0);
        w_re     = tw_re_rom[tw_k];
        w_im     = tw_im_rom[tw_k];
        if (inv_q) begin
            if (tw_im_rom[tw_k] == {1'b1, {(TW_W-1){1'b0}}})
                w_im = {1'b0, {(TW_W-1){1'b1}}};
            else
                w_im = -tw_im_rom[tw_k];
        end
    end

    fft_bfly #(
        .DATA_W (DATA_W),
        .TW_W   (TW_W)
    ) u_bfly (
        .a_re     (mem[top_addr].re),
        .a_im     (mem[top_addr].im),
        .b_re     (mem[bot_addr].re),
        .b_im     (mem[bot_addr].im),
        .w_re     (w_re),
        .w_im     (w_im),
        .bypass   (bypass),
        .top_re_c (top_res.re),
        .top_im_c (top_res.im),
        .bot_re_c (bot_res.re),
        .bot_im_c (bot_res.im)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stage_d     = stage_q;
        bfly_d      = bfly_q;
        inv_d       = inv_q;
        in_ready_d  = in_ready;
        out_valid_d = out_valid;
        out_real_d  = out_real;
        out_imag_d  = out_imag;
        out_index_d = out_index;
        out_last_d  = out_last;
        busy_d      = busy;
        wr_ld       = 1'b0;
        wr_bf       = 1'b0;
        case (state_q)
            LOAD: begin
                if (in_valid && in_ready) begin
                    wr_ld = 1'b1;
                    cnt_d = cnt_q + LOG2N'(1);
                    if (cnt_q == '0)
                        inv_d = inv;
                    if (cnt_q == LOG2N'(N - 1)) begin
                        state_d    = COMPUTE;
                        in_ready_d = 1'b0;
                        busy_d     = 1'b1;
                    end
                end
            end
            COMPUTE: begin
                wr_bf  = 1'b1;
                bfly_d = bfly_q + BW'(1);
                if (bfly_q == BW'(HALF - 1)) begin
                    stage_d = stage_q + LOG2N'(1);
                    if (stage_q == LOG2N'(LOG2N - 1)) begin
                        stage_d = '0;
                        state_d = UNLOAD;
                    end
                end
            end
            UNLOAD: begin
                // An output register is refilled whenever it is empty or was just consumed.
                if (!out_valid || out_ready) begin
                    if (out_valid && out_last) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        in_ready_d  = 1'b1;
                        busy_d      = 1'b0;
                        state_d     = LOAD;
                    end else begin
                        out_valid_d = 1'b1;
                        out_real_d  = mem[cnt_q].re;
                        out_imag_d  = mem[cnt_q].im;
                        out_index_d = cnt_q;
                        out_last_d  = (cnt_q == LOG2N'(N - 1));
                        cnt_d       = cnt_q + LOG2N'(1);
                    end
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= LOAD;
            cnt_q     <= '0;
            stage_q   <= '0;
            bfly_q    <= '0;
            inv_q     <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_real  <= '0;
            out_imag  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            stage_q   <= stage_d;
            bfly_q    <= bfly_d;
            inv_q     <= inv_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            out_real  <= out_real_d;
            out_imag  <= out_imag_d;
            out_index <= out_index_d;
            out_last  <= out_last_d;
            busy      <= busy_d;
        end
    end

    // Complex register file: each sample is loaded at its bit-reversed
    // address, and each butterfly writes both of its results back in place.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (wr_ld)
                mem[ld_addr] <= '{re: in_real, im: in_imag};
            if (wr_bf) begin
                mem[top_addr] <= top_res;
                mem[bot_addr] <= bot_res;
            end
        end
    end

endmodule
